// File: rtl/conv_enc_pkg.sv
// ---------------------------------------------------------------------------
// conv_enc_pkg
// Shared definitions for the terminated convolutional encoder:
//   - mode_e   : termination mode encodings carried on cfg_mode
//   - state_e  : top-level FSM states (RUN / FLUSH)
//   - DEF_K, DEF_G0, DEF_G1 : default constraint length and generators
//   - normalizeMode : folds the reserved mode onto continuous mode
// ---------------------------------------------------------------------------
package conv_enc_pkg;

    typedef enum logic [1:0] {
        MODE_CONT  = 2'd0,
        MODE_ZTAIL = 2'd1,
        MODE_RPP   = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam int                DEF_K  = 7;
    localparam logic [DEF_K-1:0]  DEF_G0 = 7'o171;
    localparam logic [DEF_K-1:0]  DEF_G1 = 7'o133;

    // The reserved encoding behaves exactly like continuous mode.
    function automatic mode_e normalizeMode(input logic [1:0] raw);
        return (raw == MODE_RSVD) ? MODE_CONT : mode_e'(raw);
    endfunction

endpackage

// File: rtl/conv_enc_step.sv
// ---------------------------------------------------------------------------
// conv_enc_step
// One combinational encoder step: shifts one information bit into the
// (K-1)-bit encoder state and produces the two coded bits.
// Ports:
//   state_i     : current encoder state, state_i[K-2] is the most recent bit
//   bit_i       : new information bit
//   coded_o     : {parity with G1, parity with G0}
//   nextState_o : encoder state after this bit
// ---------------------------------------------------------------------------
module conv_enc_step
    import conv_enc_pkg::*;
#(
    parameter int             K  = DEF_K,
    parameter logic [K-1:0]   G0 = DEF_G0,
    parameter logic [K-1:0]   G1 = DEF_G1
) (
    input  logic [K-2:0] state_i,
    input  logic         bit_i,
    output logic [1:0]   coded_o,
    output logic [K-2:0] nextState_o
);

    logic [K-1:0] window;

    // The newest bit sits at the top of the window; the oldest bit falls out
    // of the bottom when the window becomes the next state.
    always_comb begin
        window      = {bit_i, state_i};
        coded_o     = {^(window & G1), ^(window & G0)};
        nextState_o = window[K-1:1];
    end

endmodule

// File: rtl/conv_enc_term.sv
// ---------------------------------------------------------------------------
// conv_enc_term
// Rate-1/2 convolutional encoder on an AXI-Stream style interface with
// selectable packet termination (continuous, zero-tail, reset-per-packet).
// Ports:
//   ce_clk, ce_rst          : clock, synchronous active-high reset
//   cfg_mode                : termination mode, latched at packet start
//   s_axis_tdata/tlast/tvalid/tready : IN_W information bits per beat,
//                             bit 0 is first in time
//   m_axis_tdata/tlast/tvalid/tready : 2*IN_W coded bits per beat,
//                             registered output
//   stat_pkt_cnt            : number of output packets completed (wraps)
// ---------------------------------------------------------------------------
module conv_enc_term
    import conv_enc_pkg::*;
#(
    parameter int             IN_W = 8,
    parameter int             K    = DEF_K,
    parameter logic [K-1:0]   G0   = DEF_G0,
    parameter logic [K-1:0]   G1   = DEF_G1
) (
    input  logic                ce_clk,
    input  logic                ce_rst,
    input  logic [1:0]          cfg_mode,
    input  logic [IN_W-1:0]     s_axis_tdata,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [2*IN_W-1:0]   m_axis_tdata,
    output logic                m_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [15:0]         stat_pkt_cnt
);

    localparam int SW = K - 1;

    state_e              state_q, state_d;
    mode_e               modeLatched_q, modeLatched_d;
    logic                midPkt_q, midPkt_d;
    logic [SW-1:0]       encState_q, encState_d;
    logic                outValid_q, outValid_d;
    logic                outLast_q, outLast_d;
    logic [2*IN_W-1:0]   outData_q, outData_d;
    logic [15:0]         pktCnt_q, pktCnt_d;

    logic [IN_W:0][SW-1:0] beatChain;
    logic [2*IN_W-1:0]     beatCoded;
    logic [SW:0][SW-1:0]   flushChain;
    logic [2*SW-1:0]       flushCoded;
    logic [2*IN_W-1:0]     flushWord;

    mode_e beatMode;
    logic  outFree;
    logic  outXfer;
    logic  sReady;
    logic  accept;
    logic  loadFlush;

    // Encoder chain for a full input beat: one step per bit, bit 0 first,
    // with the state rippling from one step into the next.
    assign beatChain[0] = encState_q;

    for (genvar i = 0; i < IN_W; i++) begin : gBeat
        conv_enc_step #(.K(K), .G0(G0), .G1(G1)) uStep (
            .state_i     (beatChain[i]),
            .bit_i       (s_axis_tdata[i]),
            .coded_o     (beatCoded[2*i +: 2]),
            .nextState_o (beatChain[i+1])
        );
    end

    // Tail chain: K-1 zero bits drive the encoder back to the all-zero
    // state, so flushChain[SW] is always zero and doubles as the cleared
    // state once the flush word has been taken.
    assign flushChain[0] = encState_q;

    for (genvar j = 0; j < SW; j++) begin : gFlush
        conv_enc_step #(.K(K), .G0(G0), .G1(G1)) uStep (
            .state_i     (flushChain[j]),
            .bit_i       (1'b0),
            .coded_o     (flushCoded[2*j +: 2]),
            .nextState_o (flushChain[j+1])
        );
    end

    // Tail bits occupy the low end of the flush word; the rest is padding.
    always_comb begin
        flushWord               = '0;
        flushWord[2*SW-1:0]     = flushCoded;
    end

    // State register for the FSM plus all datapath registers.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state_q       <= ST_RUN;
            modeLatched_q <= MODE_CONT;
            midPkt_q      <= 1'b0;
            encState_q    <= '0;
            outValid_q    <= 1'b0;
            outLast_q     <= 1'b0;
            outData_q     <= '0;
            pktCnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            modeLatched_q <= modeLatched_d;
            midPkt_q      <= midPkt_d;
            encState_q    <= encState_d;
            outValid_q    <= outValid_d;
            outLast_q     <= outLast_d;
            outData_q     <= outData_d;
            pktCnt_q      <= pktCnt_d;
        end
    end

    // Next-state logic: a zero-tail packet end parks the FSM in FLUSH until
    // the output register is free to take the flush word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept && s_axis_tlast && (beatMode == MODE_ZTAIL)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (loadFlush) begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // Output and datapath logic. The mode of a packet's first beat comes
    // straight from cfg_mode; later beats use the value latched then. A
    // flush load and a beat accept never coincide because tready is low
    // throughout FLUSH.
    always_comb begin
        outFree   = !outValid_q || m_axis_tready;
        outXfer   = outValid_q && m_axis_tready;
        sReady    = !ce_rst && (state_q == ST_RUN) && outFree;
        accept    = sReady && s_axis_tvalid;
        loadFlush = (state_q == ST_FLUSH) && outFree;
        beatMode  = midPkt_q ? modeLatched_q : normalizeMode(cfg_mode);

        modeLatched_d = modeLatched_q;
        midPkt_d      = midPkt_q;
        encState_d    = encState_q;
        outValid_d    = outValid_q;
        outLast_d     = outLast_q;
        outData_d     = outData_q;
        pktCnt_d      = pktCnt_q;

        if (outXfer) begin
            outValid_d = 1'b0;
            if (outLast_q) begin
                pktCnt_d = pktCnt_q + 16'd1;
            end
        end

        if (accept) begin
            outValid_d = 1'b1;
            outData_d  = beatCoded;
            outLast_d  = s_axis_tlast && (beatMode != MODE_ZTAIL);
            midPkt_d   = !s_axis_tlast;
            if (!midPkt_q) begin
                modeLatched_d = beatMode;
            end
            if (s_axis_tlast && (beatMode == MODE_RPP)) begin
                encState_d = '0;
            end else begin
                encState_d = beatChain[IN_W];
            end
        end

        if (loadFlush) begin
            outValid_d = 1'b1;
            outData_d  = flushWord;
            outLast_d  = 1'b1;
            encState_d = flushChain[SW];
        end
    end

    assign s_axis_tready = sReady;
    assign m_axis_tdata  = outData_q;
    assign m_axis_tlast  = outLast_q;
    assign m_axis_tvalid = outValid_q;
    assign stat_pkt_cnt  = pktCnt_q;

endmodule

// File: tb/tb_conv_enc_term.sv
// ---------------------------------------------------------------------------
// tb_conv_enc_term
// Self-checking bench for conv_enc_term (IN_W=8, K=7, G0=171o, G1=133o).
// A bit-serial reference model predicts every output word into a queue; a
// monitor compares each transfer against it and checks hold-while-stalled.
// Directed sequences add fixed expected words, and random data, modes,
// packet ends and downstream backpressure exercise the stream path.
// ---------------------------------------------------------------------------
module tb_conv_enc_term;

    localparam int         IN_W = 8;
    localparam int         K    = 7;
    localparam logic [6:0] G0   = 7'o171;
    localparam logic [6:0] G1   = 7'o133;

    logic          ce_clk = 1'b0;
    logic          ce_rst = 1'b1;
    logic [1:0]    cfg_mode = 2'd0;
    logic [7:0]    s_axis_tdata = 8'd0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [15:0]   m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [15:0]   stat_pkt_cnt;

    int            errors = 0;
    int            checks = 0;
    logic [16:0]   expQ[$];
    int            refState = 0;
    logic          refMid = 1'b0;
    logic [1:0]    refMode = 2'd0;
    int            readyMode = 0;
    logic          prevStall = 1'b0;
    logic [16:0]   prevWord = '0;

    conv_enc_term #(.IN_W(IN_W), .K(K), .G0(G0), .G1(G1)) dut (
        .ce_clk        (ce_clk),
        .ce_rst        (ce_rst),
        .cfg_mode      (cfg_mode),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .stat_pkt_cnt  (stat_pkt_cnt)
    );

    always #5 ce_clk = ~ce_clk;

    // Downstream ready: held low, held high, or a coin flip every cycle.
    always @(negedge ce_clk) begin
        #1;
        case (readyMode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference encoder: shifts bits in one at a time, newest bit at the top
    // of a K-bit window, and takes the parity of the tapped positions.
    task automatic encodeBits(input logic [31:0] bits, input int n,
                              output logic [15:0] word);
        int w;
        word = '0;
        for (int i = 0; i < n; i++) begin
            w = (int'(bits[i]) << (K - 1)) | refState;
            word[2*i]   = 1'($countones(w & int'(G0)) % 2);
            word[2*i+1] = 1'($countones(w & int'(G1)) % 2);
            refState    = w >> 1;
        end
    endtask

    // Packet-level behaviour: the mode is fixed by the first beat; zero-tail
    // ends with an extra tail word, reset-per-packet restarts from zero.
    task automatic modelBeat(input logic [7:0] d, input logic l, input logic [1:0] m);
        logic [1:0]  md;
        logic [15:0] word;
        if (refMid) begin
            md = refMode;
        end else begin
            md = (m == 2'd3) ? 2'd0 : m;
            refMode = md;
        end
        encodeBits({24'd0, d}, IN_W, word);
        if (l && md == 2'd1) begin
            expQ.push_back({1'b0, word});
            encodeBits(32'd0, K - 1, word);
            expQ.push_back({1'b1, word});
            refState = 0;
        end else begin
            expQ.push_back({l, word});
            if (l && md == 2'd2) refState = 0;
        end
        refMid = !l;
    endtask

    // Presents one beat and returns on the clock edge that accepts it.
    task automatic applyStimulus(input logic [7:0] d, input logic l, input logic [1:0] m);
        int waited = 0;
        @(negedge ce_clk);
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        cfg_mode      = m;
        s_axis_tvalid = 1'b1;
        #2;
        while (!s_axis_tready && waited < 1000) begin
            @(negedge ce_clk);
            #2;
            waited++;
        end
        if (!s_axis_tready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            s_axis_tvalid = 1'b0;
            return;
        end
        @(posedge ce_clk);
        modelBeat(d, l, m);
    endtask

    task automatic idleInputs();
        @(negedge ce_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge ce_clk);
        ce_rst        = 1'b1;
        s_axis_tvalid = 1'b0;
        expQ.delete();
        refState = 0;
        refMid   = 1'b0;
        refMode  = 2'd0;
        repeat (2) @(negedge ce_clk);
        #2;
        checkOutput("rst_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tlast",  32'(m_axis_tlast),  32'd0);
        checkOutput("rst_tdata",  32'(m_axis_tdata),  32'd0);
        checkOutput("rst_pktcnt", 32'(stat_pkt_cnt),  32'd0);
        @(negedge ce_clk);
        ce_rst = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expQ.size() != 0 || m_axis_tvalid) && n < 2000) begin
            @(negedge ce_clk);
            #3;
            n++;
        end
        checkOutput("drain_left", 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard monitor: every transfer must match the next predicted word,
    // and a stalled word must not change until it is taken.
    always @(negedge ce_clk) begin
        #2;
        if (ce_rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", 32'(m_axis_tvalid), 32'd1);
                checkOutput("stall_hold", {15'd0, m_axis_tlast, m_axis_tdata}, {15'd0, prevWord});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out", {15'd0, m_axis_tlast, m_axis_tdata}, 32'hDEAD_0000);
                end else begin
                    logic [16:0] e;
                    e = expQ.pop_front();
                    checkOutput("sb_data", 32'(m_axis_tdata), 32'(e[15:0]));
                    checkOutput("sb_last", 32'(m_axis_tlast), 32'(e[16]));
                end
            end
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevWord  = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        $display("[TB] starting conv_enc_term bench");
        readyMode = 1;
        doReset();

        // Continuous mode, single beat from the zero state.
        applyStimulus(8'h01, 1'b1, 2'd0);
        idleInputs();
        #2;
        checkOutput("m0_valid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("m0_data",  32'(m_axis_tdata),  32'h38F7);
        checkOutput("m0_last",  32'(m_axis_tlast),  32'd1);
        waitDrain();

        // Zero-tail: coded beat without tlast, then the tail word.
        doReset();
        applyStimulus(8'h80, 1'b1, 2'd1);
        idleInputs();
        #2;
        checkOutput("zt_beat_data", 32'(m_axis_tdata),  32'hC000);
        checkOutput("zt_beat_last", 32'(m_axis_tlast),  32'd0);
        checkOutput("zt_tready_lo", 32'(s_axis_tready), 32'd0);
        @(negedge ce_clk);
        #2;
        checkOutput("zt_tail_data", 32'(m_axis_tdata),  32'h0E3D);
        checkOutput("zt_tail_last", 32'(m_axis_tlast),  32'd1);
        checkOutput("zt_tready_hi", 32'(s_axis_tready), 32'd1);
        waitDrain();

        // Reset-per-packet: second packet starts from zero state again.
        doReset();
        applyStimulus(8'h80, 1'b1, 2'd2);
        idleInputs();
        #2;
        checkOutput("rpp_p1", 32'(m_axis_tdata), 32'hC000);
        applyStimulus(8'h01, 1'b1, 2'd2);
        idleInputs();
        #2;
        checkOutput("rpp_p2", 32'(m_axis_tdata), 32'h38F7);
        waitDrain();

        // Continuous mode, same stimulus: the trailing 1 carries over.
        doReset();
        applyStimulus(8'h80, 1'b1, 2'd0);
        applyStimulus(8'h01, 1'b1, 2'd0);
        idleInputs();
        #2;
        checkOutput("cont_p2", 32'(m_axis_tdata), 32'h36CA);
        checkOutput("cont_p2_differs", 32'(m_axis_tdata != 16'h38F7), 32'd1);
        waitDrain();

        // Random stream with random downstream backpressure.
        doReset();
        readyMode = 2;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) idleInputs();
            applyStimulus(8'($urandom), ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)));
        end
        idleInputs();
        readyMode = 1;
        waitDrain();

        // Reset while a zero-tail flush is pending behind a stalled output.
        doReset();
        readyMode = 0;
        applyStimulus(8'h80, 1'b1, 2'd1);
        idleInputs();
        #2;
        checkOutput("flush_stall_tready", 32'(s_axis_tready), 32'd0);
        doReset();
        readyMode = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ce_clk);
            #2;
            checkOutput("no_tail_after_rst", 32'(m_axis_tvalid), 32'd0);
        end
        applyStimulus(8'h01, 1'b1, 2'd0);
        idleInputs();
        #2;
        checkOutput("post_rst_data", 32'(m_axis_tdata), 32'h38F7);
        waitDrain();

        // Packet counter wrap: 65535 single-beat packets, then one more.
        doReset();
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(8'($urandom), 1'b1, 2'd0);
        end
        idleInputs();
        waitDrain();
        checkOutput("pktcnt_full", 32'(stat_pkt_cnt), 32'h0000_FFFF);
        applyStimulus(8'h01, 1'b1, 2'd0);
        idleInputs();
        waitDrain();
        checkOutput("pktcnt_wrap", 32'(stat_pkt_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
